// File: rtl/simple_bus_ram_arbiter.sv
// -----------------------------------------------------------------------------
// simple_bus_ram_arbiter
//
// Shares one single-port SimpleBus RAM slave between two masters
// (m0 = iBus, m1 = dBus). Single-beat round-robin arbitration, with the grant
// locked on the current master while the slave stalls. Reads push the issuing
// master's ID into an in-order FIFO, and each RAM read response pops the head
// to route the (broadcast) read data back to its issuer.
//
// Ports
//   io_mainClk, resetCtrl_systemReset_n   clock / async active-low reset
//   io_mN_cmd_*   (N=0,1)  master command channel (valid/ready + payload)
//   io_mN_rsp_*            master read response (valid + data)
//   io_s_cmd_*             slave command channel (muxed from granted master)
//   io_s_rsp_*             slave read response (valid + data)
//   io_rspOrphan           sticky flag: response arrived with no read pending
// -----------------------------------------------------------------------------
module simple_bus_ram_arbiter #(
  parameter int PEND_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              io_mainClk,
  input  logic              resetCtrl_systemReset_n,
  // master 0 (iBus)
  input  logic              io_m0_cmd_valid,
  output logic              io_m0_cmd_ready,
  input  logic              io_m0_cmd_payload_write,
  input  logic [ADDR_W-1:0] io_m0_cmd_payload_address,
  input  logic [31:0]       io_m0_cmd_payload_data,
  input  logic [3:0]        io_m0_cmd_payload_mask,
  output logic              io_m0_rsp_valid,
  output logic [31:0]       io_m0_rsp_payload_data,
  // master 1 (dBus)
  input  logic              io_m1_cmd_valid,
  output logic              io_m1_cmd_ready,
  input  logic              io_m1_cmd_payload_write,
  input  logic [ADDR_W-1:0] io_m1_cmd_payload_address,
  input  logic [31:0]       io_m1_cmd_payload_data,
  input  logic [3:0]        io_m1_cmd_payload_mask,
  output logic              io_m1_rsp_valid,
  output logic [31:0]       io_m1_rsp_payload_data,
  // RAM slave
  output logic              io_s_cmd_valid,
  input  logic              io_s_cmd_ready,
  output logic              io_s_cmd_payload_write,
  output logic [ADDR_W-1:0] io_s_cmd_payload_address,
  output logic [31:0]       io_s_cmd_payload_data,
  output logic [3:0]        io_s_cmd_payload_mask,
  input  logic              io_s_rsp_valid,
  input  logic [31:0]       io_s_rsp_payload_data,
  // status
  output logic              io_rspOrphan
);

  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CNT_W = $clog2(PEND_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(PEND_DEPTH);

  logic             rr_last_q, rr_last_d;
  logic             locked_q, locked_d;
  logic             lock_id_q, lock_id_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             orphan_q, orphan_d;
  logic             id_mem_q [PEND_DEPTH];

  logic elig0, elig1;
  logic gnt_valid, gnt_id;
  logic fire, push, pop, head_id, fifo_empty;

  // A read is only eligible while the ID FIFO has room, judged on the count
  // before this cycle's pop; writes never need a FIFO slot.
  assign fifo_empty = (count_q == '0);
  assign elig0 = io_m0_cmd_valid && (io_m0_cmd_payload_write || (count_q < DEPTH));
  assign elig1 = io_m1_cmd_valid && (io_m1_cmd_payload_write || (count_q < DEPTH));

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (locked_q) begin
      // Slave stalled last cycle: hold the grant until the command fires.
      gnt_valid = 1'b1;
      gnt_id    = lock_id_q;
    end else if (elig0 && elig1) begin
      gnt_valid = 1'b1;
      gnt_id    = ~rr_last_q;
    end else if (elig0) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (elig1) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  // Payload follows the granted master (m0 when nothing is granted).
  assign io_s_cmd_valid           = gnt_valid && (gnt_id ? elig1 : elig0);
  assign io_s_cmd_payload_write   = gnt_id ? io_m1_cmd_payload_write   : io_m0_cmd_payload_write;
  assign io_s_cmd_payload_address = gnt_id ? io_m1_cmd_payload_address : io_m0_cmd_payload_address;
  assign io_s_cmd_payload_data    = gnt_id ? io_m1_cmd_payload_data    : io_m0_cmd_payload_data;
  assign io_s_cmd_payload_mask    = gnt_id ? io_m1_cmd_payload_mask    : io_m0_cmd_payload_mask;

  assign io_m0_cmd_ready = gnt_valid && !gnt_id && elig0 && io_s_cmd_ready;
  assign io_m1_cmd_ready = gnt_valid &&  gnt_id && elig1 && io_s_cmd_ready;

  assign fire    = io_s_cmd_valid && io_s_cmd_ready;
  assign push    = fire && !io_s_cmd_payload_write;
  assign pop     = io_s_rsp_valid && !fifo_empty;
  assign head_id = id_mem_q[rd_ptr_q];

  // Response path is purely combinational: RAM data is broadcast, the FIFO
  // head selects which master sees valid.
  assign io_m0_rsp_valid        = pop && !head_id;
  assign io_m1_rsp_valid        = pop &&  head_id;
  assign io_m0_rsp_payload_data = io_s_rsp_payload_data;
  assign io_m1_rsp_payload_data = io_s_rsp_payload_data;
  assign io_rspOrphan           = orphan_q;

  always_comb begin
    rr_last_d = rr_last_q;
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    orphan_d  = orphan_q;

    if (fire) begin
      rr_last_d = gnt_id;
      locked_d  = 1'b0;
    end else if (io_s_cmd_valid) begin
      locked_d  = 1'b1;
      lock_id_d = gnt_id;
    end

    // Power-of-two depth: pointer increment wraps naturally.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (io_s_rsp_valid && fifo_empty) orphan_d = 1'b1;
  end

  always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
    if (!resetCtrl_systemReset_n) begin
      rr_last_q <= 1'b1;
      locked_q  <= 1'b0;
      lock_id_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      orphan_q  <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      orphan_q  <= orphan_d;
    end
  end

  // NOTE: the ID storage has no reset; an entry is only read after it was
  // written, because count gates every pop.
  always_ff @(posedge io_mainClk) begin
    if (push) id_mem_q[wr_ptr_q] <= gnt_id;
  end

endmodule

// File: tb/tb_simple_bus_ram_arbiter.sv
`timescale 1ns/1ps
module tb_simple_bus_ram_arbiter;

  localparam int ADDR_W     = 32;
  localparam int PEND_DEPTH = 2;
  localparam int RND_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // master-side inputs
  logic        m_valid [2];
  logic        m_write [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_mask  [2];
  // slave-side inputs
  logic        s_ready;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_data;
  // outputs
  logic        m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_data, m1_rsp_data;
  logic        s_valid, s_write, orphan;
  logic [31:0] s_addr, s_data;
  logic [3:0]  s_mask;

  simple_bus_ram_arbiter #(.PEND_DEPTH(PEND_DEPTH), .ADDR_W(ADDR_W)) dut (
    .io_mainClk                (clk),
    .resetCtrl_systemReset_n   (rst_n),
    .io_m0_cmd_valid           (m_valid[0]),
    .io_m0_cmd_ready           (m0_ready),
    .io_m0_cmd_payload_write   (m_write[0]),
    .io_m0_cmd_payload_address (m_addr[0]),
    .io_m0_cmd_payload_data    (m_data[0]),
    .io_m0_cmd_payload_mask    (m_mask[0]),
    .io_m0_rsp_valid           (m0_rsp_valid),
    .io_m0_rsp_payload_data    (m0_rsp_data),
    .io_m1_cmd_valid           (m_valid[1]),
    .io_m1_cmd_ready           (m1_ready),
    .io_m1_cmd_payload_write   (m_write[1]),
    .io_m1_cmd_payload_address (m_addr[1]),
    .io_m1_cmd_payload_data    (m_data[1]),
    .io_m1_cmd_payload_mask    (m_mask[1]),
    .io_m1_rsp_valid           (m1_rsp_valid),
    .io_m1_rsp_payload_data    (m1_rsp_data),
    .io_s_cmd_valid            (s_valid),
    .io_s_cmd_ready            (s_ready),
    .io_s_cmd_payload_write    (s_write),
    .io_s_cmd_payload_address  (s_addr),
    .io_s_cmd_payload_data     (s_data),
    .io_s_cmd_payload_mask     (s_mask),
    .io_s_rsp_valid            (s_rsp_valid),
    .io_s_rsp_payload_data     (s_rsp_data),
    .io_rspOrphan              (orphan)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One table row = one clock cycle.
  // in  = {v0, w0, v1, w1, s_ready, s_rsp_valid}
  // exp = {s_valid, m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid, orphan}
  // g   = master whose payload must appear on the slave bus when s_valid
  typedef struct packed {
    logic       rst;
    logic [5:0] in;
    logic [5:0] exp;
    logic       g;
  } vec_t;

  function automatic vec_t row(input logic rst, input logic [5:0] in,
                               input logic [5:0] exp, input logic g);
    vec_t r;
    r.rst = rst; r.in = in; r.exp = exp; r.g = g;
    return r;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic        exp_write;
    if (r.rst) pulse_reset();
    m_valid[0] = r.in[5]; m_write[0] = r.in[4];
    m_valid[1] = r.in[3]; m_write[1] = r.in[2];
    s_ready    = r.in[1]; s_rsp_valid = r.in[0];
    s_rsp_data = 32'hA5A5_0001;
    #1;
    check($sformatf("row%0d s_cmd_valid", idx),  32'(s_valid),      32'(r.exp[5]));
    check($sformatf("row%0d m0_ready", idx),     32'(m0_ready),     32'(r.exp[4]));
    check($sformatf("row%0d m1_ready", idx),     32'(m1_ready),     32'(r.exp[3]));
    check($sformatf("row%0d m0_rsp_valid", idx), 32'(m0_rsp_valid), 32'(r.exp[2]));
    check($sformatf("row%0d m1_rsp_valid", idx), 32'(m1_rsp_valid), 32'(r.exp[1]));
    check($sformatf("row%0d orphan", idx),       32'(orphan),       32'(r.exp[0]));
    if (r.exp[5]) begin
      exp_addr  = r.g ? 32'h0000_0024 : 32'h0000_0010;
      exp_mask  = r.g ? 4'b0100 : 4'hF;
      exp_write = r.g ? r.in[2] : r.in[4];
      check($sformatf("row%0d s_addr", idx),  s_addr,         exp_addr);
      check($sformatf("row%0d s_mask", idx),  32'(s_mask),    32'(exp_mask));
      check($sformatf("row%0d s_write", idx), 32'(s_write),   32'(exp_write));
    end
    if (r.exp[2]) check($sformatf("row%0d m0_rsp_data", idx), m0_rsp_data, 32'hA5A5_0001);
    if (r.exp[1]) check($sformatf("row%0d m1_rsp_data", idx), m1_rsp_data, 32'hA5A5_0001);
    @(negedge clk);
  endtask

  vec_t vecs [27];

  // Random-phase reference state: transaction-level view of the arbiter.
  logic        pend [2];
  int          mdl_ids[$];          // IDs of reads issued, oldest first
  logic [31:0] exp_rsp[2][$];       // read data each master is owed
  logic [31:0] ram_q[$];            // RAM responses not yet returned
  logic [31:0] ram_mem [16];
  int          last_winner;
  logic        held;
  int          held_id;

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_valid[n] = 1'b0; m_write[n] = 1'b0; pend[n] = 1'b0;
    end
    m_addr[0] = 32'h0000_0010; m_data[0] = 32'h1111_2222; m_mask[0] = 4'hF;
    m_addr[1] = 32'h0000_0024; m_data[1] = 32'h00CC_0000; m_mask[1] = 4'b0100;
    s_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_data = '0;

    // single m0 read
    vecs[0]  = row(1, 6'b100010, 6'b110000, 0);
    vecs[1]  = row(0, 6'b000011, 6'b000100, 0);
    // both masters reading back-to-back: m0,m1,m0,m1, responses routed
    vecs[2]  = row(1, 6'b101010, 6'b110000, 0);
    vecs[3]  = row(0, 6'b101011, 6'b101100, 1);
    vecs[4]  = row(0, 6'b101011, 6'b110010, 0);
    vecs[5]  = row(0, 6'b101011, 6'b101100, 1);
    vecs[6]  = row(0, 6'b000011, 6'b000010, 0);
    // m1 write stalled 3 cycles; m0 arrives but grant stays on m1
    vecs[7]  = row(0, 6'b001100, 6'b100000, 1);
    vecs[8]  = row(0, 6'b101100, 6'b100000, 1);
    vecs[9]  = row(0, 6'b101100, 6'b100000, 1);
    vecs[10] = row(0, 6'b101110, 6'b101000, 1);
    vecs[11] = row(0, 6'b100010, 6'b110000, 0);
    vecs[12] = row(0, 6'b000011, 6'b000100, 0);
    // fill the ID FIFO: third read blocked, a write still fires
    vecs[13] = row(0, 6'b100010, 6'b110000, 0);
    vecs[14] = row(0, 6'b100010, 6'b110000, 0);
    vecs[15] = row(0, 6'b101110, 6'b101000, 1);
    vecs[16] = row(0, 6'b100010, 6'b000000, 0);
    vecs[17] = row(0, 6'b100011, 6'b000100, 0);
    vecs[18] = row(0, 6'b100011, 6'b110100, 0);
    vecs[19] = row(0, 6'b000011, 6'b000100, 0);
    // orphan response sets the sticky flag one cycle later
    vecs[20] = row(0, 6'b000011, 6'b000000, 0);
    vecs[21] = row(0, 6'b000010, 6'b000001, 0);
    vecs[22] = row(0, 6'b000000, 6'b000001, 0);
    // m1 read outstanding, m0 write leaves rr on m0, then reset
    vecs[23] = row(0, 6'b001010, 6'b101001, 1);
    vecs[24] = row(0, 6'b110010, 6'b110001, 0);
    vecs[25] = row(1, 6'b101010, 6'b110000, 0);
    vecs[26] = row(0, 6'b000011, 6'b000100, 0);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset s_cmd_valid", 32'(s_valid), 32'd0);
    check("reset orphan",      32'(orphan),  32'd0);
    @(negedge clk);

    for (int i = 0; i < 27; i++) apply_row(vecs[i], i);

    // ---------------- randomized phase ----------------
    pulse_reset();
    for (int i = 0; i < 16; i++) ram_mem[i] = $urandom;
    last_winner = 1; held = 1'b0; held_id = 0;
    for (int n = 0; n < 2; n++) begin
      m_valid[n] = 1'b0; pend[n] = 1'b0;
    end

    for (int cyc = 0; cyc < RND_CYCLES; cyc++) begin
      logic want [2];
      logic has_g, exp_sv, rsp_now;
      int   g;
      logic [3:0] idx;

      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 1) == 1)) begin
          pend[n]    = 1'b1;
          m_write[n] = ($urandom_range(0, 2) == 0);
          m_addr[n]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          m_data[n]  = $urandom;
          m_mask[n]  = 4'($urandom_range(0, 15));
        end
        m_valid[n] = pend[n];
      end
      s_ready     = ($urandom_range(0, 3) != 0);
      rsp_now     = (ram_q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rsp_valid = rsp_now;
      s_rsp_data  = rsp_now ? ram_q[0] : $urandom;
      #1;

      // Who may be served, and who wins.
      for (int n = 0; n < 2; n++)
        want[n] = pend[n] && (m_write[n] || (mdl_ids.size() < PEND_DEPTH));
      has_g = 1'b1;
      if (held)                  g = held_id;
      else if (want[0] && want[1]) g = 1 - last_winner;
      else if (want[0])          g = 0;
      else if (want[1])          g = 1;
      else begin has_g = 1'b0; g = 0; end
      exp_sv = has_g && want[g];

      check($sformatf("rnd%0d s_cmd_valid", cyc), 32'(s_valid), 32'(exp_sv));
      check($sformatf("rnd%0d m0_ready", cyc), 32'(m0_ready), 32'(exp_sv && g == 0 && s_ready));
      check($sformatf("rnd%0d m1_ready", cyc), 32'(m1_ready), 32'(exp_sv && g == 1 && s_ready));
      if (exp_sv) check($sformatf("rnd%0d s_addr", cyc), s_addr, m_addr[g]);
      check($sformatf("rnd%0d m0_rsp_valid", cyc), 32'(m0_rsp_valid),
            32'(rsp_now && mdl_ids.size() > 0 && mdl_ids[0] == 0));
      check($sformatf("rnd%0d m1_rsp_valid", cyc), 32'(m1_rsp_valid),
            32'(rsp_now && mdl_ids.size() > 0 && mdl_ids[0] == 1));

      if (rsp_now) begin
        void'(ram_q.pop_front());
        if (mdl_ids.size() > 0) begin
          int who;
          who = mdl_ids.pop_front();
          if (exp_rsp[who].size() > 0)
            check($sformatf("rnd%0d m%0d_rsp_data", cyc, who),
                  who == 0 ? m0_rsp_data : m1_rsp_data, exp_rsp[who].pop_front());
        end
      end

      if (exp_sv && s_ready) begin
        idx = m_addr[g][5:2];
        if (m_write[g]) begin
          for (int b = 0; b < 4; b++)
            if (m_mask[g][b]) ram_mem[idx][8*b +: 8] = m_data[g][8*b +: 8];
        end else begin
          mdl_ids.push_back(g);
          ram_q.push_back(ram_mem[idx]);
          exp_rsp[g].push_back(ram_mem[idx]);
        end
        pend[g]     = 1'b0;
        last_winner = g;
        held        = 1'b0;
      end else if (exp_sv) begin
        held    = 1'b1;
        held_id = g;
      end
      @(negedge clk);
    end
    #1;
    check("rnd orphan stays low", 32'(orphan), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
